// File: rtl/serial_frame_sender_pkg.sv
// Shared definitions for the serial frame sender and the port distributor
// that consumes its line: field widths, line levels, FSM encoding, the
// latched request record and an MSB-alignment helper.
package serial_frame_sender_pkg;
  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = (1 << LEN_W) - 1;
  localparam int CNT_W  = LEN_W;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_STOP
  } state_t;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } frame_req_t;

  // Move the n live low bits of v to the top so the first bit to send is the MSB.
  function automatic logic [DATA_W-1:0] msb_align(input logic [DATA_W-1:0] v,
                                                  input logic [LEN_W-1:0]  n);
    return v << (DATA_W - int'(n));
  endfunction
endpackage

// File: rtl/serial_frame_sender_if.sv
// Frame request / status bundle between the producer (master) and the
// serial frame sender (slave).
//   start, port_sel, data_len, data : request, sampled on accept
//   ready, busy, done               : sender status
interface serial_frame_sender_if;
  import serial_frame_sender_pkg::*;
  logic              start;
  logic [PORT_W-1:0] port_sel;
  logic [LEN_W-1:0]  data_len;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (output start, port_sel, data_len, data, input ready, busy, done);
  modport slave  (input start, port_sel, data_len, data, output ready, busy, done);
endinterface

// File: rtl/serial_frame_sender_shift.sv
// frame_shift_reg: loadable MSB-first shift register plus a count of the
// bits remaining in the current field (current bit included).
// The bit on the line is registered by the caller, so this holds only the
// bits after it; next_bit is the one that goes out on the next shift.
//   clk, rst     : clock, synchronous active-high reset
//   clkEn        : bit-time enable, nothing moves while low
//   load, shift  : load a new field / advance one bit (load wins)
//   load_rem     : field bits after its first, MSB-aligned
//   load_cnt     : field width
//   next_bit     : bit that follows the current one
//   cnt          : bits remaining in the field
module frame_shift_reg #(
  parameter int W     = 15,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             load,
  input  logic             shift,
  input  logic [W-2:0]     load_rem,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             next_bit,
  output logic [CNT_W-1:0] cnt
);
  logic [W-2:0] rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      cnt <= '0;
    end else if (clkEn) begin
      if (load) begin
        rem <= load_rem;
        cnt <= load_cnt;
      end else if (shift) begin
        rem <= {rem[W-3:0], 1'b0};
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign next_bit = rem[W-2];
endmodule

// File: rtl/serial_frame_sender.sv
// serial_frame_sender: serializes one frame request onto the single-wire
// line: start(0), port MSB-first, length MSB-first, payload MSB-first.
// Optional macro SER_STOP_BIT_EN appends one high stop bit per frame.
//   clk, rst : clock, synchronous active-high reset
//   clkEn    : bit-time enable, one bit per enabled cycle
//   fr       : request/status interface (slave side)
//   ser_out  : serial line, idle high
module serial_frame_sender
  import serial_frame_sender_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  serial_frame_sender_if.slave fr,
  output logic                 ser_out
);
  state_t            state, state_nxt;
  frame_req_t        req_q;
  logic              ser_nxt, done_nxt, accept, last_field;
  logic              load, shift, next_bit;
  logic [DATA_W-1:0] load_val;
  logic [CNT_W-1:0]  load_cnt, cnt;
  logic              ready_q, busy_q, done_q;

  frame_shift_reg #(.W(DATA_W), .CNT_W(CNT_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .load     (load),
    .shift    (shift),
    .load_rem (load_val[DATA_W-2:0]),
    .load_cnt (load_cnt),
    .next_bit (next_bit),
    .cnt      (cnt)
  );

  // Each field's first bit goes straight from load_val to the line; the
  // shifter supplies the rest, and cnt==1 marks the field's final bit.
  always_comb begin
    state_nxt  = state;
    ser_nxt    = ser_out;
    done_nxt   = 1'b0;
    accept     = 1'b0;
    last_field = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    load_val   = '0;
    load_cnt   = '0;
    if (clkEn) begin
      unique case (state)
        S_IDLE: if (fr.start) begin
          accept    = 1'b1;
          state_nxt = S_START;
          ser_nxt   = START_LEVEL;
        end
        S_START: begin
          load      = 1'b1;
          load_val  = {req_q.port, {(DATA_W-PORT_W){1'b0}}};
          load_cnt  = CNT_W'(PORT_W);
          ser_nxt   = load_val[DATA_W-1];
          state_nxt = S_PORT;
        end
        S_PORT: if (cnt > CNT_W'(1)) begin
          shift   = 1'b1;
          ser_nxt = next_bit;
        end else begin
          load      = 1'b1;
          load_val  = {req_q.len, {(DATA_W-LEN_W){1'b0}}};
          load_cnt  = CNT_W'(LEN_W);
          ser_nxt   = load_val[DATA_W-1];
          state_nxt = S_LEN;
        end
        S_LEN: if (cnt > CNT_W'(1)) begin
          shift   = 1'b1;
          ser_nxt = next_bit;
        end else if (req_q.len != '0) begin
          load      = 1'b1;
          load_val  = msb_align(req_q.data, req_q.len);
          load_cnt  = req_q.len;
          ser_nxt   = load_val[DATA_W-1];
          state_nxt = S_DATA;
        end else begin
          last_field = 1'b1;
        end
        S_DATA: if (cnt > CNT_W'(1)) begin
          shift   = 1'b1;
          ser_nxt = next_bit;
        end else begin
          last_field = 1'b1;
        end
`ifdef SER_STOP_BIT_EN
        S_STOP: begin
          state_nxt = S_IDLE;
          ser_nxt   = IDLE_LEVEL;
          done_nxt  = 1'b1;
        end
`endif
        default: begin
          state_nxt = S_IDLE;
          ser_nxt   = IDLE_LEVEL;
        end
      endcase

      if (last_field) begin
`ifdef SER_STOP_BIT_EN
        state_nxt = S_STOP;
        ser_nxt   = IDLE_LEVEL;
`else
        state_nxt = S_IDLE;
        ser_nxt   = IDLE_LEVEL;
        done_nxt  = 1'b1;
`endif
      end
    end
  end

  // done_nxt is low on disabled cycles, so the pulse is one clk wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ser_out <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state   <= state_nxt;
      ser_out <= ser_nxt;
      ready_q <= (state_nxt == S_IDLE);
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= done_nxt;
      if (accept) req_q <= '{port: fr.port_sel, len: fr.data_len, data: fr.data};
    end
  end

  assign fr.ready = ready_q;
  assign fr.busy  = busy_q;
  assign fr.done  = done_q;
endmodule

// File: tb/tb_serial_frame_sender.sv
module tb_serial_frame_sender;
  import serial_frame_sender_pkg::*;

`ifdef SER_STOP_BIT_EN
  localparam int STOP_BITS = 1;
`else
  localparam int STOP_BITS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clkEn;
  logic ser_out;

  serial_frame_sender_if fr ();

  serial_frame_sender dut (
    .clk     (clk),
    .rst     (rst),
    .clkEn   (clkEn),
    .fr      (fr),
    .ser_out (ser_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int en_per   = 0;
  int phase    = 0;
  int hi_run   = 0;
  int last_hi  = 0;
  int gap_hi   = 0;
  int last_wait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then update clkEn for the next edge and track runs of high line.
  task automatic step();
    @(posedge clk);
    #1;
    case (en_per)
      0: clkEn = 1'b0;
      1: clkEn = 1'b1;
      default: begin
        phase = (phase + 1) % en_per;
        clkEn = (phase == 0);
      end
    endcase
    if (ser_out === 1'b1) hi_run++;
    else begin
      last_hi = hi_run;
      hi_run  = 0;
    end
  endtask

  task automatic set_per(input int p);
    en_per = p;
    phase  = 0;
    clkEn  = (p != 0);
  endtask

  task automatic scramble();
    fr.port_sel = PORT_W'($urandom);
    fr.data_len = LEN_W'($urandom);
    fr.data     = DATA_W'($urandom);
  endtask

  // Reference: the frame is the list of line levels, one per bit time.
  task automatic send_frame(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [DATA_W-1:0] d, input bit hold,
                            input bit noise, input int abort_at);
    bit q[$];
    int waits, busy_cnt, guard, per;
    bit acc, pe, pr;
    q.push_back(1'b0);
    for (int k = PORT_W-1; k >= 0; k--) q.push_back(p[k]);
    for (int k = LEN_W-1; k >= 0; k--) q.push_back(l[k]);
    for (int k = int'(l)-1; k >= 0; k--) q.push_back(d[k]);
    for (int k = 0; k < STOP_BITS; k++) q.push_back(1'b1);
    per = (en_per < 1) ? 1 : en_per;

    fr.start = 1'b1; fr.port_sel = p; fr.data_len = l; fr.data = d;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 100) begin
      pe = clkEn; pr = fr.ready;
      step();
      waits++;
      if (pe && pr) acc = 1'b1;
      chk("done_not_set", 32'(fr.done), 32'd0);
    end
    chk("accept", 32'(acc), 32'd1);
    if (!acc) return;
    last_wait = waits;
    gap_hi    = last_hi;
    if (!hold) fr.start = 1'b0;
    scramble();

    busy_cnt = 0;
    foreach (q[i]) begin
      chk("ser_bit", 32'(ser_out), 32'(q[i]));
      chk("busy_in_frame", 32'(fr.busy), 32'd1);
      chk("ready_in_frame", 32'(fr.ready), 32'd0);
      chk("done_in_frame", 32'(fr.done), 32'd0);
      if (i == abort_at) begin
        fr.start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ser", 32'(ser_out), 32'd1);
        chk("abort_ready", 32'(fr.ready), 32'd1);
        chk("abort_busy", 32'(fr.busy), 32'd0);
        chk("abort_done", 32'(fr.done), 32'd0);
        step(); step();
        chk("abort_no_done", 32'(fr.done), 32'd0);
        chk("abort_idle_ser", 32'(ser_out), 32'd1);
        return;
      end
      if (!hold) begin
        if (noise && i < q.size()-1) begin
          fr.start = 1'($urandom_range(1, 0));
          scramble();
        end else fr.start = 1'b0;
      end
      guard = 0;
      do begin
        pe = clkEn;
        step();
        busy_cnt++;
        guard++;
        if (!pe) chk("ser_frozen", 32'(ser_out), 32'(q[i]));
      end while (!pe && guard < 10);
      chk("bit_timeout", 32'(pe), 32'd1);
    end
    chk("end_ready", 32'(fr.ready), 32'd1);
    chk("end_busy", 32'(fr.busy), 32'd0);
    chk("end_done", 32'(fr.done), 32'd1);
    chk("end_ser", 32'(ser_out), 32'd1);
    chk("busy_len", 32'(busy_cnt), 32'(q.size() * per));
  endtask

  initial begin
    rst = 1'b1;
    fr.start = 1'b0; fr.port_sel = '0; fr.data_len = '0; fr.data = '0;
    set_per(0);
    step(); step();
    chk("rst_ser", 32'(ser_out), 32'd1);
    chk("rst_ready", 32'(fr.ready), 32'd1);
    chk("rst_busy", 32'(fr.busy), 32'd0);
    chk("rst_done", 32'(fr.done), 32'd0);
    rst = 1'b0;
    fr.start = 1'b1;
    step(); step(); step();
    chk("hold_ser", 32'(ser_out), 32'd1);
    chk("hold_ready", 32'(fr.ready), 32'd1);
    chk("hold_busy", 32'(fr.busy), 32'd0);
    fr.start = 1'b0;

    // Empty payload, then an 8-bit payload, continuous enable.
    set_per(1);
    send_frame(2'd3, 4'd0, 15'h0000, 1'b0, 1'b0, -1);
    step();
    chk("done_width", 32'(fr.done), 32'd0);
    send_frame(2'd2, 4'd8, 15'h00A5, 1'b0, 1'b0, -1);
    step();
    chk("done_width", 32'(fr.done), 32'd0);

    // Enable one cycle in three.
    set_per(3);
    send_frame(2'd1, 4'd1, 15'h0001, 1'b0, 1'b0, -1);
    step();
    chk("done_width_slow", 32'(fr.done), 32'd0);

    // Mid-frame starts and field changes are ignored; then abort at bit 5.
    set_per(1);
    send_frame(2'd2, 4'd5, 15'h0013, 1'b0, 1'b1, -1);
    step();
    send_frame(2'd0, 4'd6, DATA_W'($urandom), 1'b0, 1'b0, 5);

    // Back-to-back with start held high; first frame ends on a low bit.
    send_frame(2'd1, 4'd1, 15'h0000, 1'b1, 1'b0, -1);
    send_frame(2'd2, 4'd3, 15'h0005, 1'b0, 1'b0, -1);
    chk("b2b_wait", 32'(last_wait), 32'd1);
    chk("b2b_high_bits", 32'(gap_hi), 32'(1 + STOP_BITS));
    step();

    // Random frames, random enable rate, random mid-frame noise.
    for (int n = 0; n < 12; n++) begin
      set_per(int'($urandom_range(3, 1)));
      send_frame(PORT_W'($urandom), LEN_W'($urandom), DATA_W'($urandom),
                 1'b0, 1'($urandom_range(1, 0)), -1);
      step();
      chk("rand_done_width", 32'(fr.done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
